// File: rtl/seven_seg_scan_capture.sv
// seven_seg_scan_capture: rebuilds four hex digits from a time-multiplexed seven-segment anode/cathode bus
// Ports: clk; rst_n async active-low reset; an[3:0] active-low anodes (bit0 = va10); seg[6:0] active-low {ca..cg};
//   va10..va13 captured digits; digit_valid per-digit status; seg_err undecodable-pattern pulse;
//   frame_done all-four-captured pulse. Macro SEG_CAPTURE_ERRCNT_EN adds err_clr input and err_cnt[7:0].
module seven_seg_scan_capture #(
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [6:0] seg,
`ifdef SEG_CAPTURE_ERRCNT_EN
  input  logic       err_clr,
  output logic [7:0] err_cnt,
`endif
  output logic [3:0] va10,
  output logic [3:0] va11,
  output logic [3:0] va12,
  output logic [3:0] va13,
  output logic [3:0] digit_valid,
  output logic       seg_err,
  output logic       frame_done
);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2;
  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  logic [3:0] an1_q, an2_q, anp_q;
  logic [6:0] seg1_q, seg2_q, segp_q;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d, mask_set, dv_q;
  logic [3:0] va_q [4];
  logic err_q, done_q;
  logic one_hot, changed, fire, hit, done;
  logic [1:0] idx;
  logic [3:0] val;
  assign one_hot = (an2_q == 4'b1110) || (an2_q == 4'b1101) || (an2_q == 4'b1011) || (an2_q == 4'b0111);
  assign idx = !an2_q[0] ? 2'd0 : !an2_q[1] ? 2'd1 : !an2_q[2] ? 2'd2 : 2'd3;
  assign changed = {an2_q, seg2_q} != {anp_q, segp_q};
  // A change landing on the terminal count suppresses the capture.
  assign fire = (state_q == SETTLE) && one_hot && !changed && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
  always_comb begin
    hit = 1'b0;
    val = 4'd0;
    for (int k = 0; k < 16; k++)
      if (seg2_q == GLYPH[k]) begin
        hit = 1'b1;
        val = 4'(k);
      end
  end
  assign mask_set = hit ? (mask_q | (4'b0001 << idx)) : mask_q;
  assign done = fire && hit && (mask_set == 4'hF);
  assign mask_d = done ? 4'd0 : fire ? mask_set : mask_q;
  always_comb begin
    state_d = (state_q == IDLE)   ? (one_hot ? SETTLE : IDLE) :
              (state_q == SETTLE) ? ((changed || !one_hot) ? IDLE : fire ? HOLD : SETTLE) :
              (changed ? IDLE : HOLD);
    cnt_d   = (state_q == IDLE)   ? (one_hot ? CNT_W'(1) : '0) :
              (state_q == SETTLE) ? ((changed || !one_hot || fire) ? '0 : cnt_q + CNT_W'(1)) :
              '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      an1_q   <= 4'hF;
      an2_q   <= 4'hF;
      anp_q   <= 4'hF;
      seg1_q  <= 7'h7F;
      seg2_q  <= 7'h7F;
      segp_q  <= 7'h7F;
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      dv_q    <= '0;
      va_q    <= '{default: '0};
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      an1_q   <= an;
      an2_q   <= an1_q;
      anp_q   <= an2_q;
      seg1_q  <= seg;
      seg2_q  <= seg1_q;
      segp_q  <= seg2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      err_q   <= fire && !hit;
      done_q  <= done;
      if (fire) dv_q[idx] <= hit;
      if (fire && hit) va_q[idx] <= val;
    end
  assign va10 = va_q[0];
  assign va11 = va_q[1];
  assign va12 = va_q[2];
  assign va13 = va_q[3];
  assign digit_valid = dv_q;
  assign seg_err = err_q;
  assign frame_done = done_q;
`ifdef SEG_CAPTURE_ERRCNT_EN
  logic [7:0] ecnt_q, ecnt_d;
  assign ecnt_d = err_clr ? 8'd0 : (err_q && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ecnt_q <= '0;
    else ecnt_q <= ecnt_d;
  assign err_cnt = ecnt_q;
`endif
endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// tb_seven_seg_scan_capture: directed checks of the seven-segment scan capture with STABLE_CYCLES=4
module tb_seven_seg_scan_capture;
  localparam logic [6:0] G3 = 7'b0000110, GA = 7'b0001000, G7 = 7'b0001111, GE = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0100100, G8 = 7'b0000000, BAD = 7'h7F, GLT = 7'b0000111;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] an;
  logic [6:0] seg;
  logic [3:0] va10, va11, va12, va13, digit_valid;
  logic seg_err, frame_done;
  int checks, fails;
`ifdef SEG_CAPTURE_ERRCNT_EN
  logic err_clr;
  logic [7:0] err_cnt;
`endif
  seven_seg_scan_capture #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .an(an),
    .seg(seg),
`ifdef SEG_CAPTURE_ERRCNT_EN
    .err_clr(err_clr),
    .err_cnt(err_cnt),
`endif
    .va10(va10),
    .va11(va11),
    .va12(va12),
    .va13(va13),
    .digit_valid(digit_valid),
    .seg_err(seg_err),
    .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    an = 4'hF;
    seg = 7'h7F;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
    an = 4'b1110;
    seg = G3;
    step(4);
    checks++;
    if (dut.state_q !== 2'd1) begin $display("FAIL reset_presettle state=%0d want=1", dut.state_q); fails++; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({va13, va12, va11, va10, digit_valid, seg_err, frame_done} !== 22'd0) begin
      $display("FAIL reset_outputs got=%h want=0", {va13, va12, va11, va10, digit_valid, seg_err, frame_done}); fails++;
    end
    checks++;
    if (dut.state_q !== 2'd0) begin $display("FAIL reset_state got=%0d want=0", dut.state_q); fails++; end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++;
      if ({digit_valid, va10, seg_err} !== 9'd0) begin
        $display("FAIL reset_nocapture cyc=%0d got=%h want=0", i, {digit_valid, va10, seg_err}); fails++;
      end
    end
    an = 4'hF;
    seg = 7'h7F;
    step(8);
  endtask
  task automatic test_four_digit();
    logic [3:0] ans [4];
    logic [6:0] gl [4];
    int fd_cnt, fd_win, fd_cyc;
    ans = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    gl = '{G3, GA, G7, GE};
    fd_cnt = 0;
    fd_win = -1;
    fd_cyc = -1;
    for (int d = 0; d < 4; d++) begin
      an = ans[d];
      seg = gl[d];
      for (int c = 0; c < 10; c++) begin
        step(1);
        if (frame_done === 1'b1) begin fd_cnt++; fd_win = d; fd_cyc = c; end
      end
    end
    checks++;
    if ({va13, va12, va11, va10} !== 16'hE7A3) begin $display("FAIL four_values got=%h want=e7a3", {va13, va12, va11, va10}); fails++; end
    checks++;
    if (digit_valid !== 4'hF) begin $display("FAIL four_valid got=%b want=1111", digit_valid); fails++; end
    checks++;
    if (fd_cnt !== 1) begin $display("FAIL four_frame_count got=%0d want=1", fd_cnt); fails++; end
    checks++;
    if (fd_win !== 3 || fd_cyc !== 6) begin $display("FAIL four_frame_time got=%0d/%0d want=3/6", fd_win, fd_cyc); fails++; end
  endtask
  task automatic test_invalid_glyph();
    int errs, fds, ecyc;
    an = 4'b1101;
    seg = G5;
    step(10);
    checks++;
    if (va11 !== 4'h5) begin $display("FAIL invalid_setup va11=%h want=5", va11); fails++; end
    seg = BAD;
    errs = 0;
    fds = 0;
    ecyc = -1;
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (seg_err === 1'b1) begin errs++; ecyc = c; end
      if (frame_done === 1'b1) fds++;
    end
    checks++;
    if (errs !== 1 || ecyc !== 6) begin $display("FAIL invalid_err pulses=%0d cyc=%0d want=1/6", errs, ecyc); fails++; end
    checks++;
    if (fds !== 0) begin $display("FAIL invalid_frame got=%0d want=0", fds); fails++; end
    checks++;
    if (va11 !== 4'h5) begin $display("FAIL invalid_keep va11=%h want=5", va11); fails++; end
    checks++;
    if (digit_valid !== 4'b1101) begin $display("FAIL invalid_valid got=%b want=1101", digit_valid); fails++; end
  endtask
  task automatic test_glitch();
    an = 4'b1110;
    seg = G8;
    step(10);
    checks++;
    if (va10 !== 4'h8) begin $display("FAIL glitch_setup va10=%h want=8", va10); fails++; end
    an = 4'hF;
    seg = 7'h7F;
    step(4);
    an = 4'b1110;
    seg = G3;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) seg = GLT;
      step(1);
      checks++;
      if (va10 !== 4'h8 || seg_err !== 1'b0) begin
        $display("FAIL glitch_pre cyc=%0d va10=%h err=%b want=8/0", c, va10, seg_err); fails++;
      end
    end
    seg = G3;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      checks++;
      if ({va10, seg_err, frame_done} !== {(c >= 6) ? 4'h3 : 4'h8, 2'b00}) begin
        $display("FAIL glitch_post cyc=%0d got=%h want=%h", c, {va10, seg_err, frame_done}, {(c >= 6) ? 4'h3 : 4'h8, 2'b00}); fails++;
      end
    end
  endtask
  task automatic test_blanking();
    logic [3:0] pats [2];
    pats = '{4'hF, 4'b1100};
    seg = G3;
    for (int p = 0; p < 2; p++) begin
      an = pats[p];
      for (int c = 0; c < 20; c++) begin
        step(1);
        checks++;
        if ({va13, va12, va11, va10, digit_valid, seg_err, frame_done} !== {16'hE753, 4'b1101, 2'b00}) begin
          $display("FAIL blank an=%b cyc=%0d got=%h want=%h", an, c,
                   {va13, va12, va11, va10, digit_valid, seg_err, frame_done}, {16'hE753, 4'b1101, 2'b00}); fails++;
        end
      end
    end
  endtask
`ifdef SEG_CAPTURE_ERRCNT_EN
  task automatic test_errcnt();
    bit seen;
    checks++;
    if (err_cnt !== 8'd1) begin $display("FAIL errcnt_start got=%h want=01", err_cnt); fails++; end
    for (int n = 0; n < 300; n++) begin
      an = 4'b1101;
      seg = BAD;
      step(8);
      an = 4'hF;
      step(3);
    end
    checks++;
    if (err_cnt !== 8'hFF) begin $display("FAIL errcnt_sat got=%h want=ff", err_cnt); fails++; end
    an = 4'b1101;
    seg = BAD;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step(1);
      seen = (seg_err === 1'b1);
    end
    checks++;
    if (!seen) begin $display("FAIL errcnt_wait got=timeout want=seg_err"); fails++; end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    checks++;
    if (err_cnt !== 8'd0) begin $display("FAIL errcnt_clr got=%h want=00", err_cnt); fails++; end
    step(3);
    checks++;
    if (err_cnt !== 8'd0) begin $display("FAIL errcnt_hold got=%h want=00", err_cnt); fails++; end
    an = 4'hF;
  endtask
`endif
  initial begin
    checks = 0;
    fails = 0;
`ifdef SEG_CAPTURE_ERRCNT_EN
    err_clr = 1'b0;
`endif
    test_reset();
    test_four_digit();
    test_invalid_glyph();
    test_glitch();
    test_blanking();
`ifdef SEG_CAPTURE_ERRCNT_EN
    test_errcnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
